// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core fetch path and its SQI memory bus.
package idli_pkg;

    localparam int unsigned SQI_W            = 4;
    localparam int unsigned PC_W             = 16;
    localparam int unsigned CNT_W            = 3;
    localparam int unsigned NIB_W            = 2;
    localparam int unsigned SQI_CMD_CYCLES   = 2;
    localparam int unsigned SQI_ADDR_CYCLES  = 6;
    localparam int unsigned SQI_DUMMY_CYCLES = 2;

    localparam logic [7:0]      SQI_CMD_READ   = 8'h03;
    localparam logic [PC_W-1:0] FETCH_RESET_PC = 16'h0000;

    typedef logic [SQI_W-1:0] sqi_data_t;

    typedef enum logic [2:0] {
        FCH_CS_HIGH,
        FCH_CMD,
        FCH_ADDR,
        FCH_DUMMY,
        FCH_DATA
    } fetch_state_t;

    // Nibble of the {command, byte address} header for a given state and cycle.
    function automatic sqi_data_t sqi_hdr_nibble(input fetch_state_t st,
                                                 input logic [CNT_W-1:0] cnt,
                                                 input logic [PC_W-1:0] pc);
        logic [31:0] hdr;
        int unsigned idx;
        hdr = {SQI_CMD_READ, 7'b0, pc, 1'b0};
        idx = (st == FCH_ADDR) ? 32'(cnt) + SQI_CMD_CYCLES : 32'(cnt);
        return sqi_data_t'(hdr >> (28 - 4 * idx));
    endfunction

endpackage

// File: rtl/idli_fetch_m_if.sv
// SQI memory bus between the fetch unit and the external serial memory.
interface idli_fetch_m_if;
    import idli_pkg::*;

    logic      cs_n;
    sqi_data_t sio_out;
    logic      oe;
    sqi_data_t sio_in;

    modport fch (output cs_n, output sio_out, output oe, input sio_in);
    modport mem (input cs_n, input sio_out, input oe, output sio_in);
endinterface

// File: rtl/idli_fetch_m.sv
// Instruction fetch: issues SQI reads at the current PC and streams instruction
// nibbles to decode, restarting on redirect, reset or PC wrap.
module idli_fetch_m
    import idli_pkg::*;
(
    input  logic            i_fch_gck,
    input  logic            i_fch_rst,
    input  logic            i_fch_redirect,
    input  logic [PC_W-1:0] i_fch_redirect_pc,
    output logic            o_fch_sqi_cs_n,
    output sqi_data_t       o_fch_sqi_sio,
    output logic            o_fch_sqi_oe,
    input  sqi_data_t       i_fch_sqi_sio,
    output sqi_data_t       o_fch_enc,
    output logic            o_fch_enc_vld,
    output logic [PC_W-1:0] o_fch_pc,
    output logic            o_fch_flush
);

    fetch_state_t     state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [NIB_W-1:0] nib, nxt_nib;
    logic [PC_W-1:0]  nxt_pc;
    logic             nxt_cs_n, nxt_oe, nxt_vld, nxt_flush;
    sqi_data_t        nxt_sio;

    // Memory data is forwarded to decode without a register stage.
    assign o_fch_enc = i_fch_sqi_sio;

    // Next state, counters, PC and the bus/stream outputs for the next cycle.
    always_comb begin
        nxt_state = state;
        nxt_nib   = nib;
        nxt_pc    = o_fch_pc;
        nxt_cnt   = cnt + 3'd1;

        case (state)
            FCH_CS_HIGH: nxt_state = FCH_CMD;
            FCH_CMD:     if (cnt == CNT_W'(SQI_CMD_CYCLES - 1))   nxt_state = FCH_ADDR;
            FCH_ADDR:    if (cnt == CNT_W'(SQI_ADDR_CYCLES - 1))  nxt_state = FCH_DUMMY;
            FCH_DUMMY:   if (cnt == CNT_W'(SQI_DUMMY_CYCLES - 1)) nxt_state = FCH_DATA;
            FCH_DATA: begin
                nxt_nib = nib + 2'd1;
                if (nib == 2'd3) begin
                    nxt_pc = o_fch_pc + 16'd1;
                    // Sequential read cannot cross the top of memory; re-issue at 0.
                    if (o_fch_pc == 16'hFFFF) nxt_state = FCH_CS_HIGH;
                end
            end
            default:     nxt_state = FCH_CS_HIGH;
        endcase

        // Redirect overrides everything, including a same-cycle PC increment.
        if (i_fch_redirect) begin
            nxt_state = FCH_CS_HIGH;
            nxt_pc    = i_fch_redirect_pc;
            nxt_nib   = 2'd0;
        end

        if (i_fch_redirect || (nxt_state != state)) nxt_cnt = 3'd0;

        nxt_cs_n  = (nxt_state == FCH_CS_HIGH);
        nxt_oe    = (nxt_state == FCH_CMD) || (nxt_state == FCH_ADDR);
        nxt_sio   = nxt_oe ? sqi_hdr_nibble(nxt_state, nxt_cnt, nxt_pc) : 4'h0;
        nxt_vld   = (nxt_state == FCH_DATA);
        nxt_flush = i_fch_redirect;
    end

    // State and registered outputs; reset wins over redirect.
    always_ff @(posedge i_fch_gck) begin
        if (i_fch_rst) begin
            state          <= FCH_CS_HIGH;
            cnt            <= 3'd0;
            nib            <= 2'd0;
            o_fch_pc       <= FETCH_RESET_PC;
            o_fch_sqi_cs_n <= 1'b1;
            o_fch_sqi_oe   <= 1'b0;
            o_fch_sqi_sio  <= 4'h0;
            o_fch_enc_vld  <= 1'b0;
            o_fch_flush    <= 1'b0;
        end else begin
            state          <= nxt_state;
            cnt            <= nxt_cnt;
            nib            <= nxt_nib;
            o_fch_pc       <= nxt_pc;
            o_fch_sqi_cs_n <= nxt_cs_n;
            o_fch_sqi_oe   <= nxt_oe;
            o_fch_sqi_sio  <= nxt_sio;
            o_fch_enc_vld  <= nxt_vld;
            o_fch_flush    <= nxt_flush;
        end
    end

endmodule

// File: tb/tb_idli_fetch_m.sv
// Directed bench for idli_fetch_m with a small SQI serial-memory model.
module tb_idli_fetch_m;
    import idli_pkg::*;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    sqi_data_t   enc;
    logic        enc_vld;
    logic [15:0] pc;
    logic        flush;

    int n_cmp = 0;
    int n_err = 0;

    idli_fetch_m_if sqi ();

    idli_fetch_m dut (
        .i_fch_gck         (clk),
        .i_fch_rst         (rst),
        .i_fch_redirect    (redirect),
        .i_fch_redirect_pc (redirect_pc),
        .o_fch_sqi_cs_n    (sqi.cs_n),
        .o_fch_sqi_sio     (sqi.sio_out),
        .o_fch_sqi_oe      (sqi.oe),
        .i_fch_sqi_sio     (sqi.sio_in),
        .o_fch_enc         (enc),
        .o_fch_enc_vld     (enc_vld),
        .o_fch_pc          (pc),
        .o_fch_flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents by word address.
    function automatic logic [15:0] memw(input logic [15:0] w);
        case (w)
            16'h0000: return 16'hC123;
            16'h0001: return 16'h4567;
            16'h0040: return 16'hA5B6;
            16'hFFFF: return 16'h9E8D;
            default:  return w ^ 16'h3C3C;
        endcase
    endfunction

    // Memory model: counts cycles since chip select fell, captures the address,
    // then returns word nibbles MSB first from the captured word address onward.
    logic [31:0] m_cnt;
    logic [23:0] m_addr;
    always_ff @(posedge clk) begin
        if (sqi.cs_n) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt >= 2 && m_cnt <= 7) m_addr <= {m_addr[19:0], sqi.sio_out};
        end
    end

    always_comb begin
        logic [31:0] k;
        logic [15:0] w;
        k = m_cnt - 32'd10;
        w = memw(m_addr[16:1] + 16'(k >> 2));
        sqi.sio_in = 4'h0;
        if (m_cnt >= 10) sqi.sio_in = sqi_data_t'(w >> (12 - 4 * (k & 32'd3)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Command + address phase (8 cycles) then dummy phase (2 cycles).
    task automatic hdr(input logic [31:0] nibs, input string tag);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("%s_cs_n%0d", tag, i), 32'(sqi.cs_n), 32'd0);
            chk($sformatf("%s_oe%0d", tag, i), 32'(sqi.oe), 32'd1);
            chk($sformatf("%s_sio%0d", tag, i), 32'(sqi.sio_out), 32'((nibs >> (28 - 4 * i)) & 32'hF));
            chk($sformatf("%s_flush%0d", tag, i), 32'(flush), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("%s_dmy_oe%0d", tag, i), 32'(sqi.oe), 32'd0);
            chk($sformatf("%s_dmy_sio%0d", tag, i), 32'(sqi.sio_out), 32'd0);
            chk($sformatf("%s_dmy_vld%0d", tag, i), 32'(enc_vld), 32'd0);
        end
    endtask

    // Four data nibbles of one instruction word.
    task automatic data(input logic [15:0] w, input logic [15:0] exp_pc, input string tag);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("%s_vld%0d", tag, i), 32'(enc_vld), 32'd1);
            chk($sformatf("%s_enc%0d", tag, i), 32'(enc), 32'((w >> (12 - 4 * i)) & 16'hF));
            chk($sformatf("%s_pc%0d", tag, i), 32'(pc), 32'(exp_pc));
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        tick();
        tick();
        chk("rst_cs_n", 32'(sqi.cs_n), 32'd1);
        chk("rst_oe", 32'(sqi.oe), 32'd0);
        chk("rst_sio", 32'(sqi.sio_out), 32'd0);
        chk("rst_vld", 32'(enc_vld), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);

        // Boot fetch from word 0.
        rst = 1'b0;
        chk("boot_c0_cs_n", 32'(sqi.cs_n), 32'd1);
        hdr(32'h03000000, "boot");
        data(16'hC123, 16'h0000, "w0");
        tick();
        chk("w1_pc", 32'(pc), 32'h0001);
        chk("w1_enc0", 32'(enc), 32'h4);
        tick();
        chk("w1_enc1", 32'(enc), 32'h5);
        chk("w1_vld1", 32'(enc_vld), 32'd1);

        // Redirect during the 2nd nibble of a word.
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("r40_flush", 32'(flush), 32'd1);
        chk("r40_vld", 32'(enc_vld), 32'd0);
        chk("r40_cs_n", 32'(sqi.cs_n), 32'd1);
        chk("r40_pc", 32'(pc), 32'h0040);
        hdr(32'h03000080, "r40");
        data(16'hA5B6, 16'h0040, "w40");

        // Redirect on a 4th nibble beats the PC increment.
        redirect = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect = 1'b0;
        chk("r10_pc", 32'(pc), 32'h0010);
        chk("r10_flush", 32'(flush), 32'd1);
        hdr(32'h03000020, "r10");
        data(16'h3C2C, 16'h0010, "w10");

        // Redirect to 0x0200 on the 4th nibble at pc 0x0010, held for 3 cycles.
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        chk("r200_pc", 32'(pc), 32'h0200);
        chk("r200_flush", 32'(flush), 32'd1);
        chk("r200_cs_n", 32'(sqi.cs_n), 32'd1);
        redirect_pc = 16'hFFFF;
        tick();
        chk("hold2_cs_n", 32'(sqi.cs_n), 32'd1);
        chk("hold2_flush", 32'(flush), 32'd1);
        chk("hold2_pc", 32'(pc), 32'hFFFF);
        tick();
        redirect = 1'b0;
        chk("hold3_cs_n", 32'(sqi.cs_n), 32'd1);
        chk("hold3_flush", 32'(flush), 32'd1);
        chk("hold3_oe", 32'(sqi.oe), 32'd0);

        // Single instruction at 0xFFFF, then wrap to 0 without flush.
        hdr(32'h0301FFFE, "rff");
        data(16'h9E8D, 16'hFFFF, "wff");
        tick();
        chk("wrap_cs_n", 32'(sqi.cs_n), 32'd1);
        chk("wrap_flush", 32'(flush), 32'd0);
        chk("wrap_vld", 32'(enc_vld), 32'd0);
        chk("wrap_pc", 32'(pc), 32'h0000);

        // Reset during the address phase of the re-issued read.
        for (int i = 0; i < 3; i++) tick();
        chk("pre_rst_oe", 32'(sqi.oe), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_cs_n", 32'(sqi.cs_n), 32'd1);
        chk("mid_rst_oe", 32'(sqi.oe), 32'd0);
        chk("mid_rst_vld", 32'(enc_vld), 32'd0);
        chk("mid_rst_sio", 32'(sqi.sio_out), 32'd0);
        tick();
        rst = 1'b0;
        chk("rel_cs_n", 32'(sqi.cs_n), 32'd1);
        hdr(32'h03000000, "reboot");
        data(16'hC123, 16'h0000, "rw0");
        tick();
        chk("rw1_pc", 32'(pc), 32'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
